// File: rtl/mc_controller.sv
// Multicycle MIPS main controller.
// Moore FSM sequencing fetch/decode/execute/mem/writeback with memory wait states.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       branch,
  output logic       iord,
  output logic       alusrca,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q;
  state_t state_d;

  logic is_rtype;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_addi;
  logic is_j;
  logic op_ok;

  assign is_rtype = (op == OP_RTYPE);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_addi  = (op == OP_ADDI);
  assign is_j     = (op == OP_J);
  assign op_ok    = is_rtype | is_lw | is_sw
                  | is_beq | is_addi | is_j;

  assign state = state_q;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; op is only looked at in DECODE and MEMADR.
  always_comb begin
    state_d = FETCH;
    unique case (state_q)
      FETCH: begin
        if (mem_ready) state_d = DECODE;
        else           state_d = FETCH;
      end
      DECODE: begin
        unique case (1'b1)
          is_lw,
          is_sw:    state_d = MEMADR;
          is_rtype: state_d = RTYPEEX;
          is_beq:   state_d = BEQEX;
          is_addi:  state_d = ADDIEX;
          is_j:     state_d = JEX;
          default:  state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (is_lw) state_d = MEMRD;
        else       state_d = MEMWR;
      end
      MEMRD: begin
        if (mem_ready) state_d = MEMWB;
        else           state_d = MEMRD;
      end
      MEMWB:   state_d = FETCH;
      MEMWR: begin
        if (mem_ready) state_d = FETCH;
        else           state_d = MEMWR;
      end
      RTYPEEX: state_d = RTYPEWB;
      RTYPEWB: state_d = FETCH;
      BEQEX:   state_d = FETCH;
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
      JEX:     state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Output decode; reset low suppresses every write and shows FETCH selects.
  always_comb begin
    pcwrite    = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    alusrca    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (!reset) begin
      alusrcb = 2'b01;
    end else begin
      unique case (state_q)
        FETCH: begin
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        DECODE: begin
          alusrcb = 2'b11;
          if (!op_ok) begin
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        end
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        MEMRD: begin
          iord = 1'b1;
        end
        MEMWB: begin
          memtoreg   = 1'b1;
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        MEMWR: begin
          iord       = 1'b1;
          memwrite   = 1'b1;
          instr_done = mem_ready;
        end
        RTYPEEX: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        RTYPEWB: begin
          regdst     = 1'b1;
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        BEQEX: begin
          alusrca    = 1'b1;
          aluop      = 2'b01;
          pcsrc      = 2'b01;
          branch     = 1'b1;
          instr_done = 1'b1;
        end
        ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        ADDIWB: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        JEX: begin
          pcsrc      = 2'b10;
          pcwrite    = 1'b1;
          instr_done = 1'b1;
        end
        default: begin
          pcwrite = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller.
// Cycle-by-cycle vector table plus a few counted multi-cycle sequences.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite, irwrite, regwrite, memwrite, branch;
  logic       iord, alusrca, regdst, memtoreg;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       instr_done, illegal;
  logic [3:0] state;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .mem_ready  (mem_ready),
    .pcwrite    (pcwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .branch     (branch),
    .iord       (iord),
    .alusrca    (alusrca),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .aluop      (aluop),
    .instr_done (instr_done),
    .illegal    (illegal),
    .state      (state)
  );

  // {pcw,irw,rw,mw,br,iord,asa,rd,mtr,asb[2],pcs[2],aop[2],done,ill}
  logic [16:0] outs;
  assign outs = {pcwrite, irwrite, regwrite, memwrite, branch,
                 iord, alusrca, regdst, memtoreg,
                 alusrcb, pcsrc, aluop, instr_done, illegal};

  localparam logic [16:0] E_RST   = 17'b0_0_0_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [16:0] E_FWAIT = 17'b0_0_0_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [16:0] E_FGO   = 17'b1_1_0_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [16:0] E_DEC   = 17'b0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [16:0] E_DILL  = 17'b0_0_0_0_0_0_0_0_0_11_00_00_1_1;
  localparam logic [16:0] E_MADR  = 17'b0_0_0_0_0_0_1_0_0_10_00_00_0_0;
  localparam logic [16:0] E_MRD   = 17'b0_0_0_0_0_1_0_0_0_00_00_00_0_0;
  localparam logic [16:0] E_MWB   = 17'b0_0_1_0_0_0_0_0_1_00_00_00_1_0;
  localparam logic [16:0] E_MWW   = 17'b0_0_0_1_0_1_0_0_0_00_00_00_0_0;
  localparam logic [16:0] E_MWD   = 17'b0_0_0_1_0_1_0_0_0_00_00_00_1_0;
  localparam logic [16:0] E_RTEX  = 17'b0_0_0_0_0_0_1_0_0_00_00_10_0_0;
  localparam logic [16:0] E_RTWB  = 17'b0_0_1_0_0_0_0_1_0_00_00_00_1_0;
  localparam logic [16:0] E_BEQ   = 17'b0_0_0_0_1_0_1_0_0_00_01_01_1_0;
  localparam logic [16:0] E_AIEX  = 17'b0_0_0_0_0_0_1_0_0_10_00_00_0_0;
  localparam logic [16:0] E_AIWB  = 17'b0_0_1_0_0_0_0_0_0_00_00_00_1_0;
  localparam logic [16:0] E_JEX   = 17'b1_0_0_0_0_0_0_0_0_00_10_00_1_0;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [16:0] o;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [5:0] o_p,
                     input logic m, input logic [3:0] s,
                     input logic [16:0] e);
    vec_t v;
    v.rst = r; v.op = o_p; v.mr = m; v.st = s; v.o = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s #%0d: got %h expected %h", name, idx, act, exp);
    else
      passed++;
  endtask

  initial begin
    int cyc;
    int mw_cnt;
    int rw_cnt;
    int done_cnt;
    int waits;
    bit seen;

    reset = 1'b0;
    op = 6'b0;
    mem_ready = 1'b1;
    @(posedge clk);

    // reset held 3 cycles, then first fetch
    add(0, 6'h00, 1, 4'd0, E_RST);
    add(0, 6'h00, 1, 4'd0, E_RST);
    add(0, 6'h00, 1, 4'd0, E_RST);
    add(1, 6'h00, 1, 4'd0, E_FGO);
    // R-type then addi
    add(1, 6'h00, 1, 4'd1, E_DEC);
    add(1, 6'h00, 1, 4'd6, E_RTEX);
    add(1, 6'h00, 1, 4'd7, E_RTWB);
    add(1, 6'h08, 1, 4'd0, E_FGO);
    add(1, 6'h08, 1, 4'd1, E_DEC);
    add(1, 6'h08, 1, 4'd9, E_AIEX);
    add(1, 6'h08, 1, 4'd10, E_AIWB);
    // lw, two wait states; op changes in MEMRD are ignored
    add(1, 6'h23, 1, 4'd0, E_FGO);
    add(1, 6'h23, 1, 4'd1, E_DEC);
    add(1, 6'h23, 1, 4'd2, E_MADR);
    add(1, 6'h3f, 0, 4'd3, E_MRD);
    add(1, 6'h00, 0, 4'd3, E_MRD);
    add(1, 6'h2b, 1, 4'd3, E_MRD);
    add(1, 6'h23, 1, 4'd4, E_MWB);
    // sw, one wait state; fetch wait first
    add(1, 6'h2b, 0, 4'd0, E_FWAIT);
    add(1, 6'h2b, 1, 4'd0, E_FGO);
    add(1, 6'h2b, 1, 4'd1, E_DEC);
    add(1, 6'h2b, 1, 4'd2, E_MADR);
    add(1, 6'h2b, 0, 4'd5, E_MWW);
    add(1, 6'h2b, 1, 4'd5, E_MWD);
    // beq
    add(1, 6'h04, 1, 4'd0, E_FGO);
    add(1, 6'h04, 1, 4'd1, E_DEC);
    add(1, 6'h04, 1, 4'd8, E_BEQ);
    // j
    add(1, 6'h02, 1, 4'd0, E_FGO);
    add(1, 6'h02, 1, 4'd1, E_DEC);
    add(1, 6'h02, 1, 4'd11, E_JEX);
    // illegal opcode
    add(1, 6'h3f, 1, 4'd0, E_FGO);
    add(1, 6'h3f, 1, 4'd1, E_DILL);
    add(1, 6'h3f, 0, 4'd0, E_FWAIT);
    // reset in the middle of lw
    add(1, 6'h23, 1, 4'd0, E_FGO);
    add(1, 6'h23, 1, 4'd1, E_DEC);
    add(1, 6'h23, 1, 4'd2, E_MADR);
    add(0, 6'h23, 1, 4'd3, E_RST);
    add(1, 6'h23, 0, 4'd0, E_FWAIT);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      op = vecs[i].op;
      mem_ready = vecs[i].mr;
      #1;
      chk("state", i, {28'd0, state}, {28'd0, vecs[i].st});
      chk("outs", i, {15'd0, outs}, {15'd0, vecs[i].o});
    end

    // lw with memory always ready: 5 cycles up to instr_done
    @(negedge clk);
    op = 6'h23;
    mem_ready = 1'b1;
    cyc = 0;
    seen = 0;
    rw_cnt = 0;
    while (!seen && cyc < 20) begin
      #1;
      cyc++;
      if (regwrite) rw_cnt++;
      if (instr_done) seen = 1;
      @(negedge clk);
    end
    chk("lw_cpi", 0, cyc, 5);
    chk("lw_rw", 0, rw_cnt, 1);

    // sw with three MEMWR wait cycles
    mw_cnt = 0;
    rw_cnt = 0;
    done_cnt = 0;
    waits = 0;
    cyc = 0;
    seen = 0;
    op = 6'h2b;
    while (!seen && cyc < 30) begin
      mem_ready = !(state == 4'd5 && waits < 3);
      #1;
      cyc++;
      if (state == 4'd5 && !mem_ready) waits++;
      if (memwrite) mw_cnt++;
      if (regwrite) rw_cnt++;
      if (instr_done) begin
        done_cnt++;
        seen = 1;
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    if (instr_done) done_cnt++;
    chk("sw_cyc", 0, cyc, 7);
    chk("sw_mw", 0, mw_cnt, 4);
    chk("sw_rw", 0, rw_cnt, 0);
    chk("sw_done", 0, done_cnt, 1);
    chk("sw_end", 0, {28'd0, state}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
